e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
// Execute-stage multiply/divide unit; consumes the MDUOp/MDUStart control that decode issues.
// Runs mult/multu/div/divu over a fixed multi-cycle latency, then commits the result to HI/LO.
// Also serves mfhi/mflo/mthi/mtlo.
// Busy|Start feeds the hazard unit, which stalls F/D while an MDU-class instruction sits in D.
// PARAMETERS
// MULT_CYCLES  5   cycles Busy stays high for mult/multu (>=1)
// DIV_CYCLES   10  cycles Busy stays high for div/divu (>=1)
// PORTS
// clk        in   1   rising-edge clock
// reset      in   1   synchronous, active-high
// MDUStart_E in   1   one-cycle pulse: launch op in MDUOp_E (mult/multu/div/divu only)
// MDUOp_E    in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
// SrcA_E     in   32  rs operand (forwarded)
// SrcB_E     in   32  rt operand (forwarded)
// Busy_E     out  1   operation in flight
// MDUOut_E   out  32  mfhi -> HI, mflo -> LO, else 0 (combinational)
// HI_o, LO_o out  32  architectural HI/LO (for debug/trace)
// BEHAVIOUR
// - Reset: HI=0, LO=0, Busy_E=0, counter=0, pending result=0. Reset mid-operation aborts the op.
//   - Aborted op never commits; HI/LO=0 on the next cycle.
// - Launch: MDUStart_E=1 and Busy_E=0 at edge k.
//   - Operands latched; pending {hi,lo} computed from latched values.
//   - counter loaded with MULT_CYCLES or DIV_CYCLES.
//   - Busy_E=1 in cycles k+1 .. k+N.
// - Each busy cycle, counter decrements. At the edge ending cycle k+N:
//   - HI/LO <= pending; Busy_E -> 0.
//   - New HI/LO visible in cycle k+N+1.
// - MDUStart_E while Busy_E=1: ignored (hazard unit must prevent it); state unaffected.
// - MDUStart_E with MDUOp_E not in 1..4: ignored.
// - mult:  {HI,LO} = $signed(A)*$signed(B) (64-bit).
// - multu: {HI,LO} = A*B unsigned 64-bit.
// - div:   LO = quotient truncated toward zero; HI = remainder, sign follows dividend.
//   - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
// - divu: LO = A/B, HI = A%B, unsigned.
// - Divisor 0 (div/divu): op still runs full DIV_CYCLES with Busy high; HI/LO left unchanged.
// - mthi/mtlo (no Start): HI or LO <= SrcA_E at the edge, only when Busy_E=0; ignored while busy.
// - mfhi/mflo: MDUOut_E reflects current HI/LO. Not valid while busy; the stall guarantees no read then.
// - Commit and mthi/mtlo in the same edge cannot occur (mt* ignored while busy).
// - Busy_E and HI/LO are registered; MDUOut_E is a pure mux of HI/LO by MDUOp_E.
// TESTING
// 1 reset held 2 cycles mid-mult, then released
//   -> Busy_E=0, HI=LO=0; no late commit afterwards.
// 2 mult A=0xFFFFFFFE(-2), B=3
//   -> Busy_E high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
// 3 multu A=0xFFFFFFFF, B=0xFFFFFFFF
//   -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
// 4 div A=-7, B=2
//   -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   - then divu A=7, B=0 -> HI/LO unchanged after 10 busy cycles.
// 5 mthi 0x1234 + mtlo 0x5678 back-to-back, then mfhi/mflo
//   -> MDUOut_E=0x1234 / 0x5678; mtlo issued while busy has no effect.
// 6 second MDUStart_E during busy div
//   -> ignored; Busy_E falls on original schedule; HI/LO hold first op's result.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/multu/div/divu committing to HI/LO,
// plus mfhi/mflo/mthi/mtlo access.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDUStart_E,
  input  logic [3:0]  MDUOp_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  output logic        Busy_E,
  output logic [31:0] MDUOut_E,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   count;
  logic [31:0]        hi, lo;
  logic [31:0]        pend_hi, pend_lo;
  logic               pend_skip;
  logic               launch, commit;
  logic               op_is_div;
  logic [63:0]        res_c;
  logic               div_zero_c;
  logic [31:0]        abs_a, abs_b, divisor, q_mag, r_mag;

  assign op_is_div = (MDUOp_E == OP_DIV) || (MDUOp_E == OP_DIVU);

  // Result of the op being launched, computed from the operands present at the launch edge.
  always_comb begin
    res_c      = '0;
    div_zero_c = 1'b0;
    abs_a      = SrcA_E;
    abs_b      = SrcB_E;
    divisor    = 32'd1;
    q_mag      = '0;
    r_mag      = '0;
    case (MDUOp_E)
      OP_MULT:  res_c = {{32{SrcA_E[31]}}, SrcA_E} * {{32{SrcB_E[31]}}, SrcB_E};
      OP_MULTU: res_c = {32'd0, SrcA_E} * {32'd0, SrcB_E};
      OP_DIV: begin
        // Magnitude division sidesteps the 0x80000000 / -1 overflow case.
        div_zero_c = (SrcB_E == 32'd0);
        abs_a      = SrcA_E[31] ? 32'(-SrcA_E) : SrcA_E;
        abs_b      = SrcB_E[31] ? 32'(-SrcB_E) : SrcB_E;
        divisor    = div_zero_c ? 32'd1 : abs_b;
        q_mag      = abs_a / divisor;
        r_mag      = abs_a % divisor;
        res_c[31:0]  = (SrcA_E[31] ^ SrcB_E[31]) ? 32'(-q_mag) : q_mag;
        res_c[63:32] = SrcA_E[31] ? 32'(-r_mag) : r_mag;
      end
      OP_DIVU: begin
        div_zero_c   = (SrcB_E == 32'd0);
        divisor      = div_zero_c ? 32'd1 : SrcB_E;
        res_c[31:0]  = SrcA_E / divisor;
        res_c[63:32] = SrcA_E % divisor;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (MDUStart_E && (MDUOp_E >= OP_MULT) && (MDUOp_E <= OP_DIVU)) begin
          launch     = 1'b1;
          next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (count == CNT_W'(1)) begin
          commit     = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Latency counter, pending result and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_skip <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (launch) begin
        count     <= op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_hi   <= res_c[63:32];
        pend_lo   <= res_c[31:0];
        pend_skip <= div_zero_c;
      end else if (state == S_BUSY) begin
        count <= count - CNT_W'(1);
      end

      if (commit) begin
        if (!pend_skip) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else if (state == S_IDLE) begin
        if (MDUOp_E == OP_MTHI) hi <= SrcA_E;
        if (MDUOp_E == OP_MTLO) lo <= SrcA_E;
      end
    end
  end

  assign Busy_E = (state == S_BUSY);
  assign HI_o   = hi;
  assign LO_o   = lo;

  always_comb begin
    MDUOut_E = '0;
    if (MDUOp_E == OP_MFHI) MDUOut_E = hi;
    if (MDUOp_E == OP_MFLO) MDUOut_E = lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected commits are queued at issue and checked when Busy_E falls.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MDUStart_E;
  logic [3:0]  MDUOp_E;
  logic [31:0] SrcA_E, SrcB_E;
  logic        Busy_E;
  logic [31:0] MDUOut_E, HI_o, LO_o;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUStart_E(MDUStart_E), .MDUOp_E(MDUOp_E),
    .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .Busy_E(Busy_E), .MDUOut_E(MDUOut_E),
    .HI_o(HI_o), .LO_o(LO_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endfunction

  // Monitor: measures each busy window and compares the commit against the queue head.
  int  busy_len = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_len = 0;
    end else if (Busy_E) begin
      busy_len++;
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'(busy_len), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("busy_cycles", 32'(busy_len), 32'(e.cyc));
        check("commit_hi", HI_o, e.hi);
        check("commit_lo", LO_o, e.lo);
      end
      busy_len = 0;
    end
    prev_busy = Busy_E;
  end

  task automatic issue(input logic start, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    MDUStart_E = start; MDUOp_E = op; SrcA_E = a; SrcB_E = b;
    @(posedge clk); #1;
    MDUStart_E = 1'b0; MDUOp_E = 4'd0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc;
    exp_q.push_back(e);
    issue(1'b1, op, a, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy_E && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (Busy_E) check("busy_timeout", 32'(Busy_E), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; MDUStart_E = 1'b0; MDUOp_E = 4'd0; SrcA_E = '0; SrcB_E = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(Busy_E), 32'd0);
    check("rst_hi", HI_o, 32'd0);
    check("rst_lo", LO_o, 32'd0);
    check("rst_out", MDUOut_E, 32'd0);

    // Reset mid-mult aborts without a late commit.
    issue(1'b1, 4'd1, 32'd3, 32'd4);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("abort_busy", 32'(Busy_E), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_busy_late", 32'(Busy_E), 32'd0);
    check("abort_hi", HI_o, 32'd0);
    check("abort_lo", LO_o, 32'd0);

    // Start with a non-arithmetic op must not launch anything.
    issue(1'b1, 4'd5, 32'd1, 32'd1);
    check("start_mfhi_ignored", 32'(Busy_E), 32'd0);
    issue(1'b1, 4'd0, 32'd1, 32'd1);
    check("start_none_ignored", 32'(Busy_E), 32'd0);

    launch(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_idle();
    launch(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    wait_idle();
    launch(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();
    launch(4'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();
    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    wait_idle();
    launch(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_idle();

    // mthi/mtlo back to back, then read back through the output mux.
    issue(1'b0, 4'd7, 32'h1234, 32'd0);
    issue(1'b0, 4'd8, 32'h5678, 32'd0);
    MDUOp_E = 4'd5; #1;
    check("mfhi", MDUOut_E, 32'h1234);
    MDUOp_E = 4'd6; #1;
    check("mflo", MDUOut_E, 32'h5678);
    MDUOp_E = 4'd0; #1;

    // mtlo while busy (divide by zero keeps HI/LO) has no effect.
    launch(4'd4, 32'd1, 32'd0, 32'h1234, 32'h5678, 10);
    issue(1'b0, 4'd8, 32'hDEAD, 32'd0);
    wait_idle();

    // Second start during a busy div is ignored; original schedule and result hold.
    launch(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    issue(1'b1, 4'd1, 32'd2, 32'd3);
    wait_idle();
    repeat (8) @(posedge clk);
    #1;
    check("no_extra_busy", 32'(Busy_E), 32'd0);
    check("final_hi", HI_o, 32'd2);
    check("final_lo", LO_o, 32'd14);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
